// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs loads/stores against a variable-latency data
// memory over req/ack, stalls upstream while busy, and loads the MEM/WB register.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_mem,
    input  logic [63:0] alu_result_mem,
    input  logic [63:0] Db_mem,
    input  logic [4:0]  Rd_mem,
    input  logic [3:0]  xfer_size_mem,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic        MemWrite_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [3:0]  dmem_size,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        valid_wb,
    output logic [63:0] wb_data_wb,
    output logic [4:0]  Rd_wb,
    output logic        RegWrite_wb,
    output logic        mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;
    logic        valid_wb_q, valid_wb_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic        regwrite_wb_q, regwrite_wb_d;
    logic        mem_err_q, mem_err_d;

    logic        mem_op;
    logic        abort;
    logic [63:0] rdata_ext;

    assign mem_op = valid_mem & (MemtoReg_mem | MemWrite_mem);
    assign abort  = (state_q == BUSY) && !dmem_ack && (cnt_q == CNT_LAST);

    always_comb begin
        rdata_ext = dmem_rdata;
        case (size_q)
            4'd1:    rdata_ext = {56'd0, dmem_rdata[7:0]};
            4'd2:    rdata_ext = {48'd0, dmem_rdata[15:0]};
            4'd4:    rdata_ext = {32'd0, dmem_rdata[31:0]};
            default: rdata_ext = dmem_rdata;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            if (state_q == IDLE)
                stall = mem_op;
            else
                stall = !dmem_ack && !abort;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        valid_wb_d    = valid_wb_q;
        wb_data_d     = wb_data_q;
        rd_wb_d       = rd_wb_q;
        regwrite_wb_d = regwrite_wb_q;
        mem_err_d     = mem_err_q;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d       = BUSY;
                    cnt_d         = '0;
                    req_d         = 1'b1;
                    we_d          = MemWrite_mem;
                    addr_d        = alu_result_mem;
                    wdata_d       = Db_mem;
                    size_d        = xfer_size_mem;
                    valid_wb_d    = 1'b0;
                    regwrite_wb_d = 1'b0;
                end else begin
                    valid_wb_d    = valid_mem;
                    wb_data_d     = alu_result_mem;
                    rd_wb_d       = Rd_mem;
                    regwrite_wb_d = RegWrite_mem & valid_mem;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d       = IDLE;
                    req_d         = 1'b0;
                    valid_wb_d    = 1'b1;
                    wb_data_d     = MemtoReg_mem ? rdata_ext : alu_result_mem;
                    rd_wb_d       = Rd_mem;
                    regwrite_wb_d = RegWrite_mem;
                end else if (abort) begin
                    state_d       = IDLE;
                    req_d         = 1'b0;
                    mem_err_d     = 1'b1;
                    valid_wb_d    = 1'b1;
                    wb_data_d     = alu_result_mem;
                    rd_wb_d       = Rd_mem;
                    regwrite_wb_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            valid_wb_q    <= 1'b0;
            wb_data_q     <= '0;
            rd_wb_q       <= '0;
            regwrite_wb_q <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            valid_wb_q    <= valid_wb_d;
            wb_data_q     <= wb_data_d;
            rd_wb_q       <= rd_wb_d;
            regwrite_wb_q <= regwrite_wb_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_size   = size_q;
    assign valid_wb    = valid_wb_q;
    assign wb_data_wb  = wb_data_q;
    assign Rd_wb       = rd_wb_q;
    assign RegWrite_wb = regwrite_wb_q;
    assign mem_err     = mem_err_q;

endmodule
